// File: rtl/sid_ctrl_pkg.sv
// Shared constants for the SID filter controller: register map, FSM states
// and the default frame length.
package sid_ctrl_pkg;

  localparam int SID_CLK_DIV_DEF = 24;

  localparam logic [4:0] SID_ADDR_FC_LO    = 5'h15;
  localparam logic [4:0] SID_ADDR_FC_HI    = 5'h16;
  localparam logic [4:0] SID_ADDR_RES_FILT = 5'h17;
  localparam logic [4:0] SID_ADDR_MODE_VOL = 5'h18;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ARMED = 2'd2
  } sid_state_e;

endpackage

// File: rtl/sid_filter_ctrl_if.sv
// Register-write bus and output sample handshake of the SID filter controller.
interface sid_filter_ctrl_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [14:0] out_sample;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output wr_en, wr_addr, wr_data, out_ready,
    input  out_sample, out_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, out_ready,
    output out_sample, out_valid
  );
endinterface

// File: rtl/sid_frame_div.sv
// Output-frame divider: counts 0..CLK_DIV-1 while enabled and flags the
// terminal count with wrap.
module sid_frame_div
  import sid_ctrl_pkg::*;
#(
  parameter int CLK_DIV = SID_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wrap
);

  localparam logic [11:0] CNT_MAX = 12'(CLK_DIV - 1);

  logic [11:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? 12'd0 : cnt_q + 12'd1;
    end
  end

  assign wrap = en && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 12'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sid_filter_ctrl.sv
// SID filter controller: frame timing, shadowed filter registers committed on
// filter step 0, and a one-deep output sample buffer. SID_CTRL_OVR_CNT_EN adds
// a saturating overrun counter.
//
// state    | meaning
// ST_INIT  | filter datapath held in reset for two cycles
// ST_COUNT | waiting for the frame divider to wrap
// ST_ARMED | frame due; commit on the next filt_ready
module sid_filter_ctrl
  import sid_ctrl_pkg::*;
#(
  parameter int CLK_DIV = SID_CLK_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  sid_filter_ctrl_if.slave    bus,
  input  logic [14:0]         filt_sample,
  input  logic                filt_ready,
  output logic                filt_rst,
  output logic [10:0]         reg_fc,
  output logic [7:0]          res_filt,
  output logic [7:0]          mode_vol,
  output logic [7:0]          overrun_cnt
);

  sid_state_e  state_q, state_d;
  logic        init_cnt_q, init_cnt_d;
  logic        filt_rst_q, filt_rst_d;
  logic [10:0] fc_sh_q, fc_sh_d, fc_act_q, fc_act_d;
  logic [7:0]  res_sh_q, res_sh_d, res_act_q, res_act_d;
  logic [7:0]  mv_sh_q, mv_sh_d, mv_act_q, mv_act_d;
  logic [14:0] out_sample_q, out_sample_d;
  logic        out_valid_q, out_valid_d;
  logic        wrap;
  logic        commit;

  sid_frame_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en && (state_q != ST_INIT)),
    .wrap  (wrap)
  );

  assign commit = en && (state_q == ST_ARMED) && filt_ready;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q) state_d = ST_COUNT;
        else            init_cnt_d = 1'b1;
      end
      ST_COUNT: if (wrap)   state_d = ST_ARMED;
      ST_ARMED: if (commit) state_d = ST_COUNT;
      default:              state_d = ST_INIT;
    endcase
    filt_rst_d = (state_d == ST_INIT);
  end

  // Shadow writes always land; the commit reads the pre-write shadow value.
  always_comb begin
    fc_sh_d  = fc_sh_q;
    res_sh_d = res_sh_q;
    mv_sh_d  = mv_sh_q;
    if (bus.wr_en) begin
      case (bus.wr_addr)
        SID_ADDR_FC_LO:    fc_sh_d[2:0]  = bus.wr_data[2:0];
        SID_ADDR_FC_HI:    fc_sh_d[10:3] = bus.wr_data;
        SID_ADDR_RES_FILT: res_sh_d      = bus.wr_data;
        SID_ADDR_MODE_VOL: mv_sh_d       = bus.wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    fc_act_d     = fc_act_q;
    res_act_d    = res_act_q;
    mv_act_d     = mv_act_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    if (commit) begin
      fc_act_d     = fc_sh_q;
      res_act_d    = res_sh_q;
      mv_act_d     = mv_sh_q;
      out_sample_d = filt_sample;
      out_valid_d  = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= 1'b0;
      filt_rst_q   <= 1'b1;
      fc_sh_q      <= '0;
      res_sh_q     <= '0;
      mv_sh_q      <= '0;
      fc_act_q     <= '0;
      res_act_q    <= '0;
      mv_act_q     <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      filt_rst_q   <= filt_rst_d;
      fc_sh_q      <= fc_sh_d;
      res_sh_q     <= res_sh_d;
      mv_sh_q      <= mv_sh_d;
      fc_act_q     <= fc_act_d;
      res_act_q    <= res_act_d;
      mv_act_q     <= mv_act_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifdef SID_CTRL_OVR_CNT_EN
  logic       overrun;
  logic [7:0] ovr_q, ovr_d;

  assign overrun = commit && out_valid_q && !bus.out_ready;

  always_comb begin
    ovr_d = ovr_q;
    if (overrun && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 8'd0;
    else        ovr_q <= ovr_d;
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

  assign filt_rst       = filt_rst_q;
  assign reg_fc         = fc_act_q;
  assign res_filt       = res_act_q;
  assign mode_vol       = mv_act_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: doc/sid_filter_ctrl.md
SID_FILTER_CTRL -- requirements
Module: sid_filter_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 24, clocks per output sample frame; legal range 8..4095.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: en  in  1  run enable; low freezes the divider and suppresses captures.
REQ-005 Port: wr_en  in  1  register write strobe, one write per high cycle.
REQ-006 Port: wr_addr  in  5  SID register address.
REQ-007 Port: wr_data  in  8  write data.
REQ-008 Port: filt_sample  in  15  mixed/filtered sample from the filter datapath.
REQ-009 Port: filt_ready  in  1  filter step-0 indicator, high one cycle in every 8.
REQ-010 Port: filt_rst  out  1  synchronous active-high reset to the filter datapath.
REQ-011 Port: reg_fc  out  11  active cutoff value.
REQ-012 Port: res_filt  out  8  active resonance/routing value.
REQ-013 Port: mode_vol  out  8  active mode/volume value.
REQ-014 Port: out_sample  out  15  buffered sample.
REQ-015 Port: out_valid  out  1  out_sample holds an unconsumed sample.
REQ-016 Port: out_ready  in  1  consumer accepts when high together with out_valid.
REQ-017 Port: overrun_cnt  out  8  count of lost samples.

Function
REQ-018 Writes SHALL update shadow registers in the cycle after wr_en: 0x15 -> fc[2:0] from wr_data[2:0]; 0x16 -> fc[10:3]; 0x17 -> res_filt; 0x18 -> mode_vol; other addresses ignored.
REQ-019 The FSM SHALL have states INIT, COUNT and ARMED.
REQ-020 INIT SHALL last exactly 2 cycles after reset release with filt_rst high, then go to COUNT with filt_rst low.
REQ-021 In COUNT with en high, the divider SHALL count 0..CLK_DIV-1 and wrap to 0; on reaching CLK_DIV-1 the FSM SHALL enter ARMED.
REQ-022 The divider SHALL keep running in ARMED.
REQ-023 In ARMED on a cycle with filt_ready high (commit cycle), the block SHALL:
  - load out_sample from filt_sample;
  - set out_valid;
  - copy all shadow registers to the active outputs;
  - return to COUNT.
REQ-024 A write on the commit cycle SHALL reach the shadow only; the commit uses the pre-write shadow value, and the write takes effect at the next commit.
REQ-025 out_valid SHALL clear on an out_ready&&out_valid cycle that is not a commit cycle.
REQ-026 Commit while out_valid is high and out_ready is low SHALL overwrite out_sample, keep out_valid high and count one overrun.
REQ-027 Commit with out_ready high SHALL complete the handshake on the old sample and present the new one; this is not an overrun.
REQ-028 en low SHALL hold the divider and FSM state, block commits, and leave the output handshake functional.
REQ-029 A second divider wrap while already ARMED SHALL have no additional effect.

Reset
REQ-030 During rst_n low: FSM=INIT, divider=0, filt_rst=1, shadow and active registers=0, out_sample=0, out_valid=0, overrun_cnt=0.
REQ-031 Reset mid-frame SHALL discard any pending commit and any unconsumed sample.

Configuration
REQ-032 With SID_CTRL_OVR_CNT_EN defined, overrun_cnt SHALL increment by one per overrun and saturate at 255, cleared only by reset.
REQ-033 Without SID_CTRL_OVR_CNT_EN, overrun_cnt SHALL be constant 0, no counter logic SHALL exist, and the overwrite behaviour SHALL be unchanged.

Structure
REQ-034 Package sid_ctrl_pkg SHALL hold the register address constants (0x15..0x18), the FSM state enum and the default CLK_DIV.
REQ-035 The divider SHALL be sub-module sid_frame_div (ports: clk, rst_n, en, wrap).

Verification
REQ-036 Reset release, CLK_DIV=24, en=1, filt_ready every 8th cycle -> filt_rst high for exactly 2 cycles; the first commit follows the first wrap at the next filt_ready; commits thereafter occur at 24-cycle spacing.
REQ-037 Write 0x16=0xAB and 0x15=0x5 mid-frame -> reg_fc stays 0 until the commit, then equals 0x55D.
REQ-038 Write 0x18=0x1F on the commit cycle -> mode_vol keeps its old value for that commit and reads 0x1F after the next commit.
REQ-039 out_ready held low for 3 commits -> out_sample equals the third captured value; overrun_cnt=2 with the macro defined, 0 without.
REQ-040 out_ready held high -> every sample accepted in the cycle after capture and overrun_cnt stays 0; 300 forced overruns -> overrun_cnt=255.
REQ-041 rst_n asserted while ARMED with out_valid=1 -> all outputs zero immediately, and the INIT sequence repeats on release.
